// File: rtl/bz_packet_ingress.sv
// Link-side packet ingress: validates header/tail framing and commits only whole
// 3-flit data groups (plus the header once per packet) to the deserializer FIFO.
module bz_packet_ingress #(
  parameter int NRoute = 10,
  parameter int NCnt   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_v,
  input  logic [NRoute:0] in_d,
  output logic            in_a,
  input  logic            wrfull,
  output logic            wrreq,
  output logic [NRoute:0] fifo_d,
  output logic [NCnt-1:0] pkt_cnt,
  output logic [NCnt-1:0] drop_cnt,
  output logic [NCnt-1:0] pad_cnt
);

  typedef enum logic [2:0] {HDR, D0, D1, D2, FLUSH, DISCARD} state_t;

  localparam logic [NRoute:0] PadTail = {1'b1, {NRoute{1'b0}}};

  state_t            state_q, state_d;
  logic [NRoute:0]   hdr_q, hdr_d, g0_q, g0_d, g1_q, g1_d, g2_q, g2_d;
  logic              hdr_sent_q, hdr_sent_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [NCnt-1:0]   pkt_q, pkt_d, drop_q, drop_d, pad_q, pad_d;

  logic              xfer, tail;
  logic [NRoute-1:0] data;

  function automatic logic [NCnt-1:0] sat_inc(input logic [NCnt-1:0] v);
    return (&v) ? v : v + NCnt'(1);
  endfunction

  assign tail     = in_d[NRoute];
  assign data     = in_d[NRoute-1:0];
  assign in_a     = !reset && (state_q != FLUSH);
  assign xfer     = in_v && in_a;
  assign wrreq    = !reset && (state_q == FLUSH) && !wrfull;
  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_q;
  assign pad_cnt  = pad_q;

  // Pending flit: 0 = header, 1..3 = g0..g2.
  always_comb begin
    fifo_d = hdr_q;
    case (ptr_q)
      2'd1:    fifo_d = g0_q;
      2'd2:    fifo_d = g1_q;
      2'd3:    fifo_d = g2_q;
      default: fifo_d = hdr_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    g0_d       = g0_q;
    g1_d       = g1_q;
    g2_d       = g2_q;
    hdr_sent_d = hdr_sent_q;
    ptr_d      = ptr_q;
    pkt_d      = pkt_q;
    drop_d     = drop_q;
    pad_d      = pad_q;
    case (state_q)
      HDR: if (xfer) begin
        if (tail) begin
          drop_d = sat_inc(drop_q);
        end else if (data != '0) begin
          state_d = DISCARD;
        end else begin
          hdr_d      = in_d;
          hdr_sent_d = 1'b0;
          state_d    = D0;
        end
      end
      D0: if (xfer) begin
        if (!tail) begin
          g0_d    = in_d;
          state_d = D1;
        end else if (!hdr_sent_q) begin
          drop_d  = sat_inc(drop_q);
          state_d = HDR;
        end else begin
          // Truncated continuation group: close the packet with zero padding.
          g0_d    = {1'b0, data};
          g1_d    = '0;
          g2_d    = PadTail;
          pad_d   = sat_inc(pad_q);
          ptr_d   = 2'd1;
          state_d = FLUSH;
        end
      end
      D1: if (xfer) begin
        if (!tail) begin
          g1_d    = in_d;
          state_d = D2;
        end else if (!hdr_sent_q) begin
          drop_d  = sat_inc(drop_q);
          state_d = HDR;
        end else begin
          g1_d    = {1'b0, data};
          g2_d    = PadTail;
          pad_d   = sat_inc(pad_q);
          ptr_d   = 2'd1;
          state_d = FLUSH;
        end
      end
      D2: if (xfer) begin
        g2_d    = in_d;
        ptr_d   = hdr_sent_q ? 2'd1 : 2'd0;
        state_d = FLUSH;
      end
      FLUSH: if (wrreq) begin
        if (ptr_q == 2'd3) begin
          hdr_sent_d = 1'b1;
          if (g2_q[NRoute]) begin
            pkt_d   = sat_inc(pkt_q);
            state_d = HDR;
          end else begin
            state_d = D0;
          end
        end else begin
          ptr_d = ptr_q + 2'd1;
        end
      end
      DISCARD: if (xfer && tail) begin
        drop_d  = sat_inc(drop_q);
        state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HDR;
      hdr_q      <= '0;
      g0_q       <= '0;
      g1_q       <= '0;
      g2_q       <= '0;
      hdr_sent_q <= 1'b0;
      ptr_q      <= 2'd0;
      pkt_q      <= '0;
      drop_q     <= '0;
      pad_q      <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      g0_q       <= g0_d;
      g1_q       <= g1_d;
      g2_q       <= g2_d;
      hdr_sent_q <= hdr_sent_d;
      ptr_q      <= ptr_d;
      pkt_q      <= pkt_d;
      drop_q     <= drop_d;
      pad_q      <= pad_d;
    end
  end

endmodule
